// File: rtl/rr_burst_sched_pkg.sv
// Shared arbiter types and the rotate-priority search used by the
// round-robin schedulers in this block family.
package rr_burst_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } sched_state_t;

  // Widest requester vector the shared search handles.
  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req scanning ptr, ptr+1, ... wrapping at n-1 -> 0.
  // Offsets are walked from the far end so the nearest hit is written last.
  function automatic rr_pick_t rr_next(input logic [RR_MAX_N-1:0] req,
                                       input int n, input int ptr);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int off = RR_MAX_N - 1; off >= 0; off--) begin
      if (off < n) begin
        j = ptr + off;
        if (j >= n) j = j - n;
        if (req[j[RR_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_burst_sched_if.sv
// Requester/resource side of the burst scheduler. The master side drives
// requests and beat handshakes; the scheduler (slave) returns the grant.
interface rr_burst_sched_if #(
  parameter int N  = 8,
  parameter int LN = $clog2(N)
);
  logic          clk_en;
  logic [N-1:0]  req;
  logic          beat_ack;
  logic          beat_last;
  logic          grant_valid;
  logic [LN-1:0] grant_idx;
  logic [N-1:0]  grant_oh;
  logic          burst_end;

  modport master (
    output clk_en, req, beat_ack, beat_last,
    input  grant_valid, grant_idx, grant_oh, burst_end
  );

  modport slave (
    input  clk_en, req, beat_ack, beat_last,
    output grant_valid, grant_idx, grant_oh, burst_end
  );
endinterface

// File: rtl/rr_burst_sched_pick.sv
// Combinational rotate-priority encoder: first requester at or after ptr.
module rr_pick
  import rr_burst_sched_pkg::*;
#(
  parameter int N  = 8,
  parameter int LN = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [LN-1:0] ptr_i,
  output logic [LN-1:0] idx_o,
  output logic          found_o
);

  logic [RR_MAX_N-1:0] req_ext;
  rr_pick_t            pick;

  // Widen the request vector to the shared search width and pick.
  always_comb begin
    req_ext         = '0;
    req_ext[N-1:0]  = req_i;
    pick            = rr_next(req_ext, N, int'(ptr_i));
    idx_o           = LN'(pick.idx);
    found_o         = pick.found;
  end

endmodule

// File: rtl/rr_burst_sched.sv
// Round-robin burst scheduler: one owner at a time holds the shared
// resource for up to MAX_BURST accepted beats, then priority rotates.
//
// state | meaning
// IDLE  | no owner; pick next requester from the rotating pointer
// OWN   | grant_idx owns the resource; counting accepted beats
module rr_burst_sched
  import rr_burst_sched_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_BURST = 4,
  parameter int LN        = $clog2(N),
  parameter int BW        = $clog2(MAX_BURST) + 1
) (
  input  logic             clk,
  input  logic             rst,
  rr_burst_sched_if.slave  bus
);

  sched_state_t  state_q, state_d;
  logic [LN-1:0] ptr_q, ptr_d;
  logic [LN-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0]  grant_oh_q, grant_oh_d;
  logic          grant_valid_q, grant_valid_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [LN-1:0] pick_idx;
  logic          pick_found;
  logic          owner_req;
  logic          last_beat;
  logic          burst_end_c;

  rr_pick #(.N(N), .LN(LN)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Next-state and release decision; nothing moves while clk_en is low.
  // Owner dropping its request wins over a beat in the same cycle.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_oh_d    = grant_oh_q;
    grant_valid_d = grant_valid_q;
    cnt_d         = cnt_q;
    burst_end_c   = 1'b0;
    owner_req     = bus.req[grant_idx_q];
    last_beat     = bus.beat_ack &&
                    (bus.beat_last || (cnt_q == BW'(MAX_BURST - 1)));
    if (bus.clk_en) begin
      case (state_q)
        IDLE: begin
          grant_valid_d = 1'b0;
          grant_oh_d    = '0;
          if (pick_found) begin
            grant_idx_d   = pick_idx;
            grant_oh_d    = N'(1) << pick_idx;
            grant_valid_d = 1'b1;
            cnt_d         = '0;
            state_d       = OWN;
          end
        end
        OWN: begin
          if (!owner_req || last_beat) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            grant_oh_d    = '0;
            ptr_d         = (grant_idx_q == LN'(N - 1)) ? '0 : grant_idx_q + 1'b1;
            // A reset landing on the release cycle suppresses the pulse.
            burst_end_c   = !rst;
          end else if (bus.beat_ack) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      grant_oh_q    <= '0;
      grant_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_oh_q    <= grant_oh_d;
      grant_valid_q <= grant_valid_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_oh    = grant_oh_q;
  assign bus.burst_end   = burst_end_c;

endmodule

// File: tb/tb_rr_burst_sched.sv
// Bench for rr_burst_sched: an N=8 instance for most scenarios and an N=5
// instance for the non-power-of-two wrap case. Expected owners are queued
// when requests are driven and popped when a grant appears.
module tb_rr_burst_sched;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];

  rr_burst_sched_if #(.N(8), .LN(3)) b8 ();
  rr_burst_sched_if #(.N(5), .LN(3)) b5 ();

  rr_burst_sched #(.N(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  rr_burst_sched #(.N(5), .MAX_BURST(4)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (b5)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at the negedge where a grant was first seen.
  task automatic wait_grant(input int which, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      if ((which == 5) ? (b5.grant_valid === 1'b1) : (b8.grant_valid === 1'b1)) ok = 1'b1;
      else begin
        next_cycle();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b8.clk_en = 1'b1; b8.req = 8'hFF; b8.beat_ack = 1'b0; b8.beat_last = 1'b0;
    b5.clk_en = 1'b1; b5.req = 5'h00; b5.beat_ack = 1'b0; b5.beat_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (b8.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", b8.grant_valid); end
      checks++;
      if (b8.grant_oh !== 8'h00) begin errors++; $display("FAIL reset_oh got=%0h exp=00", b8.grant_oh); end
      checks++;
      if (b8.grant_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", b8.grant_idx); end
      checks++;
      if (b8.burst_end !== 1'b0) begin errors++; $display("FAIL reset_burst_end got=%0b exp=0", b8.burst_end); end
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    int         beats = 0;
    int         idle = 0;
    int         budget = 0;
    int         exp;
    bit         in_burst = 1'b0;
    bit         have_prev = 1'b0;
    logic [7:0] oh_e;
    for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
    b8.req = 8'hFF; b8.beat_ack = 1'b1; b8.beat_last = 1'b0;
    while ((exp_q.size() > 0 || in_burst) && budget < 150) begin
      next_cycle();
      @(negedge clk);
      budget++;
      if (b8.grant_valid === 1'b1 && !in_burst) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rot_extra_grant got=%0d exp=none", b8.grant_idx);
        end else begin
          exp  = exp_q.pop_front();
          oh_e = 8'(1) << exp;
          if (b8.grant_idx !== 3'(exp)) begin errors++; $display("FAIL rot_idx got=%0d exp=%0d", b8.grant_idx, exp); end
          checks++;
          if (b8.grant_oh !== oh_e) begin errors++; $display("FAIL rot_oh got=%0h exp=%0h", b8.grant_oh, oh_e); end
        end
        if (have_prev) begin
          checks++;
          if (idle != 1) begin errors++; $display("FAIL rot_idle_gap got=%0d exp=1", idle); end
        end
        in_burst = 1'b1;
        beats    = 0;
      end
      if (b8.grant_valid === 1'b1 && b8.beat_ack) beats++;
      if (b8.burst_end === 1'b1) begin
        checks++;
        if (beats != 4) begin errors++; $display("FAIL rot_burst_len got=%0d exp=4", beats); end
        in_burst  = 1'b0;
        have_prev = 1'b1;
        idle      = 0;
      end else if (b8.grant_valid !== 1'b1) begin
        idle++;
      end
    end
    if (exp_q.size() > 0 || in_burst) begin
      checks++; errors++;
      $display("FAIL rot_timeout got=%0d_pending exp=0_pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_early_end();
    bit ok;
    int exp;
    next_cycle();
    b8.req = 8'h0C; b8.beat_ack = 1'b0; b8.beat_last = 1'b0;
    exp_q.push_back(2);
    exp_q.push_back(3);
    wait_grant(8, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || b8.grant_idx !== 3'(exp)) begin errors++; $display("FAIL early_idx got=%0d exp=%0d seen=%0b", b8.grant_idx, exp, ok); end
    next_cycle();
    b8.beat_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (b8.burst_end !== 1'b0) begin errors++; $display("FAIL early_beat1_end got=%0b exp=0", b8.burst_end); end
    next_cycle();
    b8.beat_last = 1'b1;
    @(negedge clk);
    checks++;
    if (b8.burst_end !== 1'b1) begin errors++; $display("FAIL early_last_end got=%0b exp=1", b8.burst_end); end
    next_cycle();
    b8.beat_ack = 1'b0; b8.beat_last = 1'b0;
    @(negedge clk);
    checks++;
    if (b8.grant_valid !== 1'b0) begin errors++; $display("FAIL early_idle_valid got=%0b exp=0", b8.grant_valid); end
    wait_grant(8, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || b8.grant_idx !== 3'(exp)) begin errors++; $display("FAIL early_next_idx got=%0d exp=%0d seen=%0b", b8.grant_idx, exp, ok); end
    next_cycle();
    b8.req = 8'h00;
    @(negedge clk);
    checks++;
    if (b8.burst_end !== 1'b1) begin errors++; $display("FAIL early_drop_end got=%0b exp=1", b8.burst_end); end
  endtask

  task automatic test_drop();
    bit ok;
    int exp;
    next_cycle();
    b8.req = 8'h20;
    exp_q.push_back(5);
    wait_grant(8, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || b8.grant_idx !== 3'(exp)) begin errors++; $display("FAIL drop_idx got=%0d exp=%0d seen=%0b", b8.grant_idx, exp, ok); end
    checks++;
    if (b8.grant_oh !== 8'h20) begin errors++; $display("FAIL drop_oh got=%0h exp=20", b8.grant_oh); end
    next_cycle();
    b8.beat_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (b8.burst_end !== 1'b0) begin errors++; $display("FAIL drop_beat_end got=%0b exp=0", b8.burst_end); end
    next_cycle();
    b8.req = 8'hDF;
    @(negedge clk);
    checks++;
    if (b8.burst_end !== 1'b1) begin errors++; $display("FAIL drop_release got=%0b exp=1", b8.burst_end); end
    exp_q.push_back(6);
    next_cycle();
    b8.beat_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (b8.grant_valid !== 1'b0) begin errors++; $display("FAIL drop_idle_valid got=%0b exp=0", b8.grant_valid); end
    wait_grant(8, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || b8.grant_idx !== 3'(exp)) begin errors++; $display("FAIL drop_next_idx got=%0d exp=%0d seen=%0b", b8.grant_idx, exp, ok); end
  endtask

  // Owner 6 is granted on entry.
  task automatic test_clk_en();
    int en_beats = 0;
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 40) begin
      next_cycle();
      b8.clk_en   = (cyc % 2 == 0);
      b8.beat_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (b8.grant_valid !== 1'b1 || b8.grant_idx !== 3'd6) begin
        errors++; $display("FAIL clken_hold got=%0b/%0d exp=1/6", b8.grant_valid, b8.grant_idx);
      end
      if (b8.clk_en) en_beats++;
      if (b8.burst_end === 1'b1) begin
        done = 1'b1;
        checks++;
        if (!b8.clk_en) begin errors++; $display("FAIL clken_end_when_disabled got=1 exp=0"); end
      end
      cyc++;
    end
    checks++;
    if (!done || en_beats != 4) begin errors++; $display("FAIL clken_beats got=%0d exp=4 ended=%0b", en_beats, done); end
    checks++;
    if (cyc != 7) begin errors++; $display("FAIL clken_cycles got=%0d exp=7", cyc); end
    next_cycle();
    b8.clk_en = 1'b1; b8.beat_ack = 1'b0;
  endtask

  task automatic test_last_first_beat();
    bit ok;
    int exp;
    b8.req = 8'h02;
    exp_q.push_back(1);
    wait_grant(8, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || b8.grant_idx !== 3'(exp)) begin errors++; $display("FAIL first_last_idx got=%0d exp=%0d seen=%0b", b8.grant_idx, exp, ok); end
    next_cycle();
    b8.beat_ack = 1'b1; b8.beat_last = 1'b1;
    @(negedge clk);
    checks++;
    if (b8.burst_end !== 1'b1) begin errors++; $display("FAIL first_last_end got=%0b exp=1", b8.burst_end); end
    next_cycle();
    b8.beat_ack = 1'b0; b8.beat_last = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int exp;
    b8.req = 8'h08;
    exp_q.push_back(3);
    wait_grant(8, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || b8.grant_idx !== 3'(exp)) begin errors++; $display("FAIL mrst_idx got=%0d exp=%0d seen=%0b", b8.grant_idx, exp, ok); end
    next_cycle();
    b8.beat_ack = 1'b1;
    @(negedge clk);
    next_cycle();
    rst = 1'b1; b8.req = 8'h0D; b8.beat_last = 1'b1;
    @(negedge clk);
    checks++;
    if (b8.burst_end !== 1'b0) begin errors++; $display("FAIL mrst_no_pulse got=%0b exp=0", b8.burst_end); end
    next_cycle();
    rst = 1'b0; b8.beat_ack = 1'b0; b8.beat_last = 1'b0;
    @(negedge clk);
    checks++;
    if (b8.grant_valid !== 1'b0 || b8.grant_oh !== 8'h00 || b8.grant_idx !== 3'd0) begin
      errors++; $display("FAIL mrst_cleared got=%0b/%0h/%0d exp=0/00/0", b8.grant_valid, b8.grant_oh, b8.grant_idx);
    end
    exp_q.push_back(0);
    wait_grant(8, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || b8.grant_idx !== 3'(exp)) begin errors++; $display("FAIL mrst_next_idx got=%0d exp=%0d seen=%0b", b8.grant_idx, exp, ok); end
    next_cycle();
    b8.req = 8'h00;
    @(negedge clk);
    checks++;
    if (b8.burst_end !== 1'b1) begin errors++; $display("FAIL mrst_release got=%0b exp=1", b8.burst_end); end
  endtask

  task automatic test_wrap5();
    bit         ok;
    int         exp;
    logic [4:0] oh_e;
    next_cycle();
    b5.req = 5'b00001;
    exp_q.push_back(0);
    wait_grant(5, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || b5.grant_idx !== 3'(exp)) begin errors++; $display("FAIL wrap_first_idx got=%0d exp=%0d seen=%0b", b5.grant_idx, exp, ok); end
    next_cycle();
    b5.req = 5'b10001; b5.beat_ack = 1'b1; b5.beat_last = 1'b1;
    @(negedge clk);
    checks++;
    if (b5.burst_end !== 1'b1) begin errors++; $display("FAIL wrap_first_end got=%0b exp=1", b5.burst_end); end
    exp_q.push_back(4);
    exp_q.push_back(0);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      b5.beat_ack = 1'b0; b5.beat_last = 1'b0;
      wait_grant(5, ok);
      exp  = exp_q.pop_front();
      oh_e = 5'(1) << exp;
      checks++;
      if (!ok || b5.grant_idx !== 3'(exp)) begin errors++; $display("FAIL wrap_idx got=%0d exp=%0d seen=%0b", b5.grant_idx, exp, ok); end
      checks++;
      if (b5.grant_oh !== oh_e) begin errors++; $display("FAIL wrap_oh got=%0b exp=%0b", b5.grant_oh, oh_e); end
      next_cycle();
      b5.beat_ack = 1'b1; b5.beat_last = 1'b1;
      @(negedge clk);
      checks++;
      if (b5.burst_end !== 1'b1) begin errors++; $display("FAIL wrap_end got=%0b exp=1", b5.burst_end); end
    end
    next_cycle();
    b5.req = 5'b00000; b5.beat_ack = 1'b0; b5.beat_last = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_early_end();
    test_drop();
    test_clk_en();
    test_last_first_beat();
    test_mid_reset();
    test_wrap5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
